// File: rtl/inst_decode.sv
// RV32I decode stage: one D-stage pipeline register holding the decoded fields
// and immediate, plus load-use hazard detection against the held instruction.
module inst_decode #(
    parameter logic [31:0] RESET_PC  = 32'h2000_0000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 STALL,
    input  logic                 FLUSH,
    input  logic [31:0]          I_PC,
    input  logic [31:0]          I_INST,
    input  logic                 I_VALID,
    output logic                 LOAD_STALL,
    output logic                 D_VALID,
    output logic [31:0]          D_PC,
    output logic [31:0]          D_INST,
    output logic [6:0]           D_OPCODE,
    output logic [4:0]           D_RD,
    output logic [4:0]           D_RS1,
    output logic [4:0]           D_RS2,
    output logic [2:0]           D_FUNCT3,
    output logic [6:0]           D_FUNCT7,
    output logic [31:0]          D_IMM,
    output logic                 D_IS_LOAD,
    output logic                 D_ILLEGAL,
    output logic [CNT_WIDTH-1:0] D_COUNT
);

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        case (op)
            7'b0110011:                                    fmt_of = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111:                        fmt_of = FMT_I;
            7'b0100011:                                    fmt_of = FMT_S;
            7'b1100011:                                    fmt_of = FMT_B;
            7'b0110111, 7'b0010111:                        fmt_of = FMT_U;
            7'b1101111:                                    fmt_of = FMT_J;
            default:                                       fmt_of = FMT_X;
        endcase
    endfunction

    logic                 valid_q, valid_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          inst_q, inst_d;
    logic [4:0]           rd_q, rd_d;
    logic [4:0]           rs1_q, rs1_d;
    logic [4:0]           rs2_q, rs2_d;
    logic [31:0]          imm_q, imm_d;
    logic                 ld_q, ld_d;
    logic                 ill_q, ill_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    fmt_e        fmt_in;
    logic [4:0]  rd_in, rs1_in, rs2_in;
    logic [31:0] imm_in;
    logic        uses_rs1, uses_rs2, load_ok;

    always_comb begin
        fmt_in = fmt_of(I_INST[6:0]);
        rd_in  = I_INST[11:7];
        rs1_in = I_INST[19:15];
        rs2_in = 5'd0;
        imm_in = 32'd0;
        case (fmt_in)
            FMT_R: rs2_in = I_INST[24:20];
            FMT_I: imm_in = {{20{I_INST[31]}}, I_INST[31:20]};
            FMT_S: begin
                rd_in  = 5'd0;
                rs2_in = I_INST[24:20];
                imm_in = {{20{I_INST[31]}}, I_INST[31:25], I_INST[11:7]};
            end
            FMT_B: begin
                rd_in  = 5'd0;
                rs2_in = I_INST[24:20];
                imm_in = {{19{I_INST[31]}}, I_INST[31], I_INST[7], I_INST[30:25],
                          I_INST[11:8], 1'b0};
            end
            FMT_U: begin
                rs1_in = 5'd0;
                imm_in = {I_INST[31:12], 12'd0};
            end
            FMT_J: begin
                rs1_in = 5'd0;
                imm_in = {{11{I_INST[31]}}, I_INST[31], I_INST[19:12], I_INST[20],
                          I_INST[30:21], 1'b0};
            end
            default: ;
        endcase
        uses_rs1 = (fmt_in == FMT_R) || (fmt_in == FMT_I) || (fmt_in == FMT_S) || (fmt_in == FMT_B);
        uses_rs2 = (fmt_in == FMT_R) || (fmt_in == FMT_S) || (fmt_in == FMT_B);
    end

    // Hazard uses the raw source fields of the incoming word, not the masked ones.
    assign LOAD_STALL = valid_q && ld_q && (rd_q != 5'd0) && I_VALID &&
                        ((uses_rs1 && (I_INST[19:15] == rd_q)) ||
                         (uses_rs2 && (I_INST[24:20] == rd_q)));

    assign load_ok = I_VALID && (I_INST != 32'd0);

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        ld_d    = ld_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        if (FLUSH || (!STALL && LOAD_STALL)) begin
            valid_d = 1'b0;
            inst_d  = 32'd0;
            rd_d    = 5'd0;
            rs1_d   = 5'd0;
            rs2_d   = 5'd0;
            imm_d   = 32'd0;
            ld_d    = 1'b0;
            ill_d   = 1'b0;
            if (FLUSH) pc_d = RESET_PC;
        end else if (!STALL) begin
            valid_d = load_ok;
            pc_d    = I_PC;
            inst_d  = load_ok ? I_INST : 32'd0;
            rd_d    = load_ok ? rd_in  : 5'd0;
            rs1_d   = load_ok ? rs1_in : 5'd0;
            rs2_d   = load_ok ? rs2_in : 5'd0;
            imm_d   = load_ok ? imm_in : 32'd0;
            ld_d    = load_ok && (I_INST[6:0] == 7'b0000011);
            ill_d   = load_ok && (fmt_in == FMT_X);
            if (load_ok) cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
            rd_q    <= 5'd0;
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            imm_q   <= 32'd0;
            ld_q    <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            ld_q    <= ld_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign D_VALID   = valid_q;
    assign D_PC      = pc_q;
    assign D_INST    = inst_q;
    assign D_OPCODE  = inst_q[6:0];
    assign D_RD      = rd_q;
    assign D_RS1     = rs1_q;
    assign D_RS2     = rs2_q;
    assign D_FUNCT3  = inst_q[14:12];
    assign D_FUNCT7  = inst_q[31:25];
    assign D_IMM     = imm_q;
    assign D_IS_LOAD = ld_q;
    assign D_ILLEGAL = ill_q;
    assign D_COUNT   = cnt_q;

endmodule

// File: tb/tb_inst_decode.sv
// Scoreboard bench for inst_decode: the driver pushes one hand-computed expected
// D-stage state per clock edge, the monitor pops and compares after each edge.
module tb_inst_decode;

    localparam logic [31:0] RPC = 32'h2000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        STALL = 1'b0;
    logic        FLUSH = 1'b0;
    logic [31:0] I_PC = 32'd0;
    logic [31:0] I_INST = 32'd0;
    logic        I_VALID = 1'b0;
    logic        LOAD_STALL, D_VALID, D_IS_LOAD, D_ILLEGAL;
    logic [31:0] D_PC, D_INST, D_IMM, D_COUNT;
    logic [6:0]  D_OPCODE, D_FUNCT7;
    logic [4:0]  D_RD, D_RS1, D_RS2;
    logic [2:0]  D_FUNCT3;

    inst_decode dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
        .I_PC(I_PC), .I_INST(I_INST), .I_VALID(I_VALID),
        .LOAD_STALL(LOAD_STALL), .D_VALID(D_VALID), .D_PC(D_PC), .D_INST(D_INST),
        .D_OPCODE(D_OPCODE), .D_RD(D_RD), .D_RS1(D_RS1), .D_RS2(D_RS2),
        .D_FUNCT3(D_FUNCT3), .D_FUNCT7(D_FUNCT7), .D_IMM(D_IMM),
        .D_IS_LOAD(D_IS_LOAD), .D_ILLEGAL(D_ILLEGAL), .D_COUNT(D_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        v;
        logic        chk_pc;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ld, ill;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    function automatic exp_t inv(input logic chk_pc, input logic [31:0] pc, input logic [31:0] cnt);
        exp_t e;
        e = '{v: 1'b0, chk_pc: chk_pc, pc: pc, inst: 32'd0, op: 7'd0, rd: 5'd0, rs1: 5'd0,
              rs2: 5'd0, f3: 3'd0, f7: 7'd0, imm: 32'd0, ld: 1'b0, ill: 1'b0, cnt: cnt};
        return e;
    endfunction

    function automatic exp_t vld(input logic [31:0] pc, input logic [31:0] inst, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                                 input logic ld, input logic ill, input logic [31:0] cnt);
        exp_t e;
        e = '{v: 1'b1, chk_pc: 1'b1, pc: pc, inst: inst, op: op, rd: rd, rs1: rs1, rs2: rs2,
              f3: f3, f7: f7, imm: imm, ld: ld, ill: ill, cnt: cnt};
        return e;
    endfunction

    // Drive one cycle of inputs, check the combinational hazard output, queue the expected state.
    task automatic step(input logic rst_b, input logic st, input logic fl, input logic iv,
                        input logic [31:0] pc, input logic [31:0] inst, input logic ls, input exp_t e);
        @(negedge CLK);
        RST = rst_b; STALL = st; FLUSH = fl; I_VALID = iv; I_PC = pc; I_INST = inst;
        #1;
        chk("load_stall", {31'd0, LOAD_STALL}, {31'd0, ls});
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("d_valid", {31'd0, D_VALID}, {31'd0, e.v});
                if (e.chk_pc) chk("d_pc", D_PC, e.pc);
                if (e.v) chk("d_inst", D_INST, e.inst);
                chk("d_opcode", {25'd0, D_OPCODE}, {25'd0, e.op});
                chk("d_rd", {27'd0, D_RD}, {27'd0, e.rd});
                chk("d_rs1", {27'd0, D_RS1}, {27'd0, e.rs1});
                chk("d_rs2", {27'd0, D_RS2}, {27'd0, e.rs2});
                chk("d_funct3", {29'd0, D_FUNCT3}, {29'd0, e.f3});
                chk("d_funct7", {25'd0, D_FUNCT7}, {25'd0, e.f7});
                chk("d_imm", D_IMM, e.imm);
                chk("d_is_load", {31'd0, D_IS_LOAD}, {31'd0, e.ld});
                chk("d_illegal", {31'd0, D_ILLEGAL}, {31'd0, e.ill});
                chk("d_count", D_COUNT, e.cnt);
            end
        end
    end

    initial begin : driver
        exp_t a;
        // reset, then back-to-back decode of each format
        step(0, 0, 0, 0, 32'd0, 32'd0, 0, inv(1, RPC, 0));
        step(1, 0, 0, 1, 32'h2000_0000, 32'h0050_0093, 0,
             vld(32'h2000_0000, 32'h0050_0093, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 0, 0, 1));
        step(1, 0, 0, 1, 32'h2000_0004, 32'hFE20_AE23, 0,
             vld(32'h2000_0004, 32'hFE20_AE23, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h7F, 32'hFFFF_FFFC, 0, 0, 2));
        step(1, 0, 0, 1, 32'h2000_0008, 32'hFE20_8CE3, 0,
             vld(32'h2000_0008, 32'hFE20_8CE3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h7F, 32'hFFFF_FFF8, 0, 0, 3));
        step(1, 0, 0, 1, 32'h2000_000C, 32'h0010_00EF, 0,
             vld(32'h2000_000C, 32'h0010_00EF, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 0, 0, 4));
        step(1, 0, 0, 1, 32'h2000_0010, 32'h1234_52B7, 0,
             vld(32'h2000_0010, 32'h1234_52B7, 7'h37, 5'd5, 5'd0, 5'd0, 3'd5, 7'h09, 32'h1234_5000, 0, 0, 5));
        // zero word, invalid fetch, illegal opcode
        step(1, 0, 0, 1, 32'h2000_0014, 32'd0, 0, inv(0, 32'd0, 5));
        step(1, 0, 0, 0, 32'h2000_0018, 32'h0050_0093, 0, inv(0, 32'd0, 5));
        step(1, 0, 0, 1, 32'h2000_001C, 32'h0000_007F, 0,
             vld(32'h2000_001C, 32'h0000_007F, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 0, 1, 6));
        // stall hold with changing inputs, then flush beats stall
        a = vld(32'h2000_0020, 32'h0050_0093, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 0, 0, 7);
        step(1, 0, 0, 1, 32'h2000_0020, 32'h0050_0093, 0, a);
        step(1, 1, 0, 1, 32'h2000_0024, 32'hFE20_AE23, 0, a);
        step(1, 1, 0, 1, 32'h2000_0028, 32'hFE20_8CE3, 0, a);
        step(1, 1, 0, 0, 32'h2000_002C, 32'h0010_00EF, 0, a);
        step(1, 1, 1, 1, 32'h2000_0030, 32'h1234_52B7, 0, inv(1, RPC, 7));
        // load-use: one bubble, then the add is taken
        step(0, 0, 0, 0, 32'd0, 32'd0, 0, inv(1, RPC, 0));
        step(1, 0, 0, 1, 32'h100, 32'h0000_A283, 0,
             vld(32'h100, 32'h0000_A283, 7'h03, 5'd5, 5'd1, 5'd0, 3'd2, 7'h00, 32'd0, 1, 0, 1));
        step(1, 0, 0, 1, 32'h104, 32'h0052_8333, 1, inv(0, 32'd0, 1));
        step(1, 0, 0, 1, 32'h104, 32'h0052_8333, 0,
             vld(32'h104, 32'h0052_8333, 7'h33, 5'd6, 5'd5, 5'd5, 3'd0, 7'h00, 32'd0, 0, 0, 2));
        // lw x0 never stalls
        step(1, 0, 0, 1, 32'h108, 32'h0000_A003, 0,
             vld(32'h108, 32'h0000_A003, 7'h03, 5'd0, 5'd1, 5'd0, 3'd2, 7'h00, 32'd0, 1, 0, 3));
        step(1, 0, 0, 1, 32'h10C, 32'h0000_0333, 0,
             vld(32'h10C, 32'h0000_0333, 7'h33, 5'd6, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 0, 0, 4));
        // lui whose rs1 field equals the load target does not stall
        step(1, 0, 0, 1, 32'h110, 32'h0000_A283, 0,
             vld(32'h110, 32'h0000_A283, 7'h03, 5'd5, 5'd1, 5'd0, 3'd2, 7'h00, 32'd0, 1, 0, 5));
        step(1, 0, 0, 1, 32'h114, 32'h1232_82B7, 0,
             vld(32'h114, 32'h1232_82B7, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h09, 32'h1232_8000, 0, 0, 6));
        // hazard through rs2 of a store
        step(1, 0, 0, 1, 32'h118, 32'h0000_A283, 0,
             vld(32'h118, 32'h0000_A283, 7'h03, 5'd5, 5'd1, 5'd0, 3'd2, 7'h00, 32'd0, 1, 0, 7));
        step(1, 0, 0, 1, 32'h11C, 32'h0050_A023, 1, inv(0, 32'd0, 7));
        step(1, 0, 0, 1, 32'h11C, 32'h0050_A023, 0,
             vld(32'h11C, 32'h0050_A023, 7'h23, 5'd0, 5'd1, 5'd5, 3'd2, 7'h00, 32'd0, 0, 0, 8));
        // reset during a pending hazard leaves no bubble behind
        step(1, 0, 0, 1, 32'h120, 32'h0000_A283, 0,
             vld(32'h120, 32'h0000_A283, 7'h03, 5'd5, 5'd1, 5'd0, 3'd2, 7'h00, 32'd0, 1, 0, 9));
        step(0, 0, 0, 1, 32'h124, 32'h0052_8333, 1, inv(1, RPC, 0));
        step(1, 0, 0, 1, 32'h124, 32'h0052_8333, 0,
             vld(32'h124, 32'h0052_8333, 7'h33, 5'd6, 5'd5, 5'd5, 3'd0, 7'h00, 32'd0, 0, 0, 1));
        @(negedge CLK);
        I_VALID = 1'b0;
        @(posedge CLK);
        #3;
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_decode.md
Name: inst_decode

Overview:
- RV32I decode stage, directly downstream of instruction fetch.
- Consumes the fetch outputs I_PC, I_INST and I_VALID. Registers the instruction into a single D-stage pipeline register with fully decoded fields and the sign-extended immediate.
- Detects load-use hazards against the instruction it currently holds and requests a fetch stall.
- Supports stall hold, flush (branch redirect) and bubble insertion.

Parameters:
- RESET_PC, 32'h2000_0000, value D_PC takes on reset and on flush.
- CNT_WIDTH, 32, width of the decoded-instruction counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-low (0 = reset).
- STALL  in  1  downstream stall; hold the D register.
- FLUSH  in  1  branch/jump redirect; kill the D-stage contents.
- I_PC  in  32  fetched instruction address.
- I_INST  in  32  fetched instruction word; 0 = none.
- I_VALID  in  1  I_PC/I_INST are valid this cycle.
- LOAD_STALL  out  1  combinational; load-use hazard detected, fetch must hold.
- D_VALID  out  1  D register holds a real instruction.
- D_PC  out  32  PC of the held instruction.
- D_INST  out  32  raw instruction word.
- D_OPCODE  out  7  inst[6:0].
- D_RD  out  5  inst[11:7]; forced to 0 for S/B types.
- D_RS1  out  5  inst[19:15]; forced to 0 for U/J types.
- D_RS2  out  5  inst[24:20]; non-zero only for R/S/B types.
- D_FUNCT3  out  3  inst[14:12].
- D_FUNCT7  out  7  inst[31:25].
- D_IMM  out  32  sign-extended immediate per format; 0 for R type.
- D_IS_LOAD  out  1  opcode 0000011.
- D_ILLEGAL  out  1  opcode is not one of the RV32I set.
- D_COUNT  out  CNT_WIDTH  number of instructions accepted into D since reset.

Behaviour:
- Reset (RST=0 at an edge): D_VALID=0, D_PC=RESET_PC, D_INST=0, all decoded fields 0, D_IS_LOAD=0, D_ILLEGAL=0, D_COUNT=0. LOAD_STALL=0 follows, because D_VALID=0.
- Update priority each edge: reset > FLUSH > STALL > LOAD_STALL > load.
  - FLUSH=1: D_VALID=0, fields cleared, D_PC=RESET_PC. FLUSH wins over a simultaneous STALL.
  - STALL=1 (no FLUSH): all D registers and D_COUNT hold.
  - LOAD_STALL=1 (no STALL, no FLUSH): bubble inserted. D_VALID=0, fields cleared, incoming instruction not consumed, D_COUNT holds.
  - Otherwise: D_VALID <= I_VALID && I_INST!=0. Decoded fields are latched from I_INST and D_PC <= I_PC. If not valid, fields are cleared.
- Latency: 1 cycle from I_VALID to D_VALID.
- Load-use hazard: LOAD_STALL = D_VALID && D_IS_LOAD && D_RD!=0 && I_VALID && ((uses_rs1(I_INST) && rs1==D_RD) || (uses_rs2(I_INST) && rs2==D_RD)).
  - uses_rs1: R, I, S, B, JALR.
  - uses_rs2: R, S, B.
  - Exactly one bubble per hazard. The following cycle D holds the bubble, so LOAD_STALL drops and the held instruction is accepted.
- Immediate formats:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - All sign-extended from bit 31 of the instruction.
- Format selection by opcode:
  - R: 0110011
  - I: 0010011, 0000011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - System/fence: 1110011, 0001111; treated as I type.
- Illegal: any other opcode while valid sets D_ILLEGAL=1. Its fields are still latched and D_VALID=1.
- D_COUNT increments by 1 on every edge where a valid instruction is loaded. It wraps modulo 2^CNT_WIDTH.
- Reset mid-stall or mid-hazard: reset wins. The next cycle starts from the reset state with no pending bubble.

Test Plan:
- Reset then I_PC=0x2000_0000, I_INST=0x00500093 (addi x1,x0,5), I_VALID=1 -> next cycle D_VALID=1, D_RD=1, D_RS1=0, D_IMM=5, D_COUNT=1.
- Back-to-back decode checks:
  - sw x2,-4(x1) (0xFE20AE23) -> D_IMM=0xFFFF_FFFC, D_RD=0, D_RS2=2.
  - beq with imm=-8 -> D_IMM=0xFFFF_FFF8.
  - jal imm=+2048 -> D_IMM=0x0000_0800.
  - lui 0x12345 -> D_IMM=0x1234_5000.
- lw x5,0(x1) followed by add x6,x5,x5 -> LOAD_STALL=1 for exactly one cycle. D_VALID=0 in the bubble cycle, then the add appears with D_PC=lw_pc+4 and D_COUNT=2 total.
- Hazard exclusions:
  - lw x0 followed by use of x0 -> LOAD_STALL stays 0.
  - lw x5 followed by lui x5 -> LOAD_STALL stays 0; lui does not read x5.
- STALL=1 for 3 cycles with changing inputs -> all D outputs and D_COUNT hold. FLUSH=1 together with STALL=1 -> D_VALID=0, D_PC=0x2000_0000.
- Boundary inputs:
  - I_INST=0 with I_VALID=1 -> D_VALID=0.
  - Opcode 0x7F -> D_ILLEGAL=1, D_VALID=1.
  - RST=0 asserted during a pending hazard -> all outputs at reset values next cycle.
